// File: rtl/dma_pkg.sv
// Shared state codes, transfer types and mode constants for the 8237-style
// DMA timing-and-control sequencer.
package dma_pkg;

  typedef logic [2:0] dmaState_t;

  localparam dmaState_t stateSI = 3'd0;
  localparam dmaState_t stateS0 = 3'd1;
  localparam dmaState_t stateS1 = 3'd2;
  localparam dmaState_t stateS2 = 3'd3;
  localparam dmaState_t stateS3 = 3'd4;
  localparam dmaState_t stateSW = 3'd5;
  localparam dmaState_t stateS4 = 3'd6;

  typedef enum logic [1:0] {
    xferVerify  = 2'b00,
    xferWrite   = 2'b01,
    xferRead    = 2'b10,
    xferIllegal = 2'b11
  } xferType_t;

  localparam logic modeSingle = 1'b0;
  localparam logic modeBlock  = 1'b1;

  // States in which the read command is on the bus and EOP_N is watched.
  function automatic logic inCmdPhase(input dmaState_t s);
    return (s == stateS2) || (s == stateS3) || (s == stateSW);
  endfunction

endpackage

// File: rtl/dma_cmd_decode.sv
// Maps a sequencer state and transfer type onto the four active-low bus
// command strobes. Verify and the illegal code produce no command at all.
module dma_cmd_decode
  import dma_pkg::*;
#(
  parameter bit EXT_WRITE = 1'b0
) (
  input  dmaState_t  state,
  input  logic [1:0] modeXfer,
  output logic       memrN,
  output logic       memwN,
  output logic       iorN,
  output logic       iowN
);

  xferType_t xfer;
  logic      readPhase;
  logic      writePhase;

  assign xfer = xferType_t'(modeXfer);

  // Extended write pulls the write command forward into S2 alongside the read.
  always_comb begin
    readPhase  = inCmdPhase(state);
    writePhase = (state == stateS3) || (state == stateSW) ||
                 (EXT_WRITE && (state == stateS2));
    memrN = 1'b1;
    memwN = 1'b1;
    iorN  = 1'b1;
    iowN  = 1'b1;
    case (xfer)
      xferWrite: begin
        iorN  = ~readPhase;
        memwN = ~writePhase;
      end
      xferRead: begin
        memrN = ~readPhase;
        iowN  = ~writePhase;
      end
      default: begin
        memrN = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dma_timing_ctrl.sv
// Timing-and-control sequencer: bus handshake, priority-resolve strobe, DACK
// enable, command strobes and address/count/terminal-count pulses.
module dma_timing_ctrl
  import dma_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter bit EXT_WRITE = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] dma_req,
  input  logic [1:0]        act_ch,
  input  logic              ctrl_disable,
  input  logic [1:0]        mode_xfer,
  input  logic              mode_block,
  input  logic              count_zero,
  input  logic              addr_hi_change,
  input  logic              HLDA,
  input  logic              READY,
  input  logic              EOP_N_in,
  output logic              HRQ,
  output logic              AEN,
  output logic              ADSTB,
  output logic              priority_gen,
  output logic              ld_ack,
  output logic              MEMR_N,
  output logic              MEMW_N,
  output logic              IOR_N,
  output logic              IOW_N,
  output logic              upd_pulse,
  output logic              tc,
  output logic              EOP_N_out
);

  dmaState_t state;
  dmaState_t nextState;
  logic      pgReg;
  logic      tcReg;
  logic      eopLatch;
  logic      memrNext, memwNext, iorNext, iowNext;
  logic      memrReg, memwReg, iorReg, iowReg;
  logic      anyReq;
  logic      unusedBits;

  // The active channel only steers DACK inside the priority logic.
  assign unusedBits = ^act_ch;
  assign anyReq     = |dma_req;

  // HLDA loss anywhere between S1 and SW abandons the cycle without an update.
  always_comb begin
    nextState = state;
    case (state)
      stateSI: if (anyReq && !ctrl_disable) nextState = stateS0;
      stateS0: begin
        if (HLDA)         nextState = stateS1;
        else if (!anyReq) nextState = stateSI;
      end
      stateS1: nextState = HLDA ? stateS2 : stateSI;
      stateS2: nextState = HLDA ? stateS3 : stateSI;
      stateS3, stateSW: begin
        if (!HLDA)      nextState = stateSI;
        else if (READY) nextState = stateS4;
        else            nextState = stateSW;
      end
      stateS4: begin
        if ((mode_block == modeSingle) || tcReg || eopLatch || ctrl_disable)
          nextState = stateSI;
        else if (addr_hi_change)
          nextState = stateS1;
        else
          nextState = stateS2;
      end
      default: nextState = stateSI;
    endcase
  end

  dma_cmd_decode #(
    .EXT_WRITE(EXT_WRITE)
  ) cmdDecode (
    .state   (nextState),
    .modeXfer(mode_xfer),
    .memrN   (memrNext),
    .memwN   (memwNext),
    .iorN    (iorNext),
    .iowN    (iowNext)
  );

  // Strobes and tc are computed for the state being entered and registered,
  // so no input reaches an output without passing a flop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= stateSI;
      pgReg    <= 1'b0;
      tcReg    <= 1'b0;
      eopLatch <= 1'b0;
      memrReg  <= 1'b1;
      memwReg  <= 1'b1;
      iorReg   <= 1'b1;
      iowReg   <= 1'b1;
    end else begin
      state   <= nextState;
      pgReg   <= (state == stateS0) && (nextState == stateS1);
      tcReg   <= (nextState == stateS4) && count_zero;
      memrReg <= memrNext;
      memwReg <= memwNext;
      iorReg  <= iorNext;
      iowReg  <= iowNext;
      if (state == stateSI)
        eopLatch <= 1'b0;
      else if (inCmdPhase(state) && !EOP_N_in)
        eopLatch <= 1'b1;
    end
  end

  assign HRQ          = (state != stateSI);
  assign AEN          = (state == stateS1) || (state == stateS2) || (state == stateS3) ||
                        (state == stateSW) || (state == stateS4);
  assign ld_ack       = AEN;
  assign ADSTB        = (state == stateS1);
  assign priority_gen = pgReg;
  assign upd_pulse    = (state == stateS4);
  assign tc           = tcReg;
  assign EOP_N_out    = ~tcReg;
  assign MEMR_N       = memrReg;
  assign MEMW_N       = memwReg;
  assign IOR_N        = iorReg;
  assign IOW_N        = iowReg;

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// Self-checking bench: scenarios are described as transfers, expanded into an
// expected per-cycle trace, and checked on two DUTs (normal and extended write).
module tb_dma_timing_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] dma_req;
  logic [1:0] act_ch;
  logic       ctrl_disable;
  logic [1:0] mode_xfer;
  logic       mode_block;
  logic       count_zero;
  logic       addr_hi_change;
  logic       HLDA;
  logic       READY;
  logic       EOP_N_in;

  logic HRQ, AEN, ADSTB, priority_gen, ld_ack, MEMR_N, MEMW_N, IOR_N, IOW_N;
  logic upd_pulse, tc, EOP_N_out;
  logic HRQx, AENx, ADSTBx, pgx, ldx, MEMRx, MEMWx, IORx, IOWx, updx, tcx, EOPx;

  logic [11:0] obs, obsX;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  dma_timing_ctrl #(.NUM_CH(4), .EXT_WRITE(1'b0)) dut (
    .CLK(CLK), .RESET(RESET), .dma_req(dma_req), .act_ch(act_ch),
    .ctrl_disable(ctrl_disable), .mode_xfer(mode_xfer), .mode_block(mode_block),
    .count_zero(count_zero), .addr_hi_change(addr_hi_change), .HLDA(HLDA),
    .READY(READY), .EOP_N_in(EOP_N_in), .HRQ(HRQ), .AEN(AEN), .ADSTB(ADSTB),
    .priority_gen(priority_gen), .ld_ack(ld_ack), .MEMR_N(MEMR_N), .MEMW_N(MEMW_N),
    .IOR_N(IOR_N), .IOW_N(IOW_N), .upd_pulse(upd_pulse), .tc(tc), .EOP_N_out(EOP_N_out)
  );

  dma_timing_ctrl #(.NUM_CH(4), .EXT_WRITE(1'b1)) dutX (
    .CLK(CLK), .RESET(RESET), .dma_req(dma_req), .act_ch(act_ch),
    .ctrl_disable(ctrl_disable), .mode_xfer(mode_xfer), .mode_block(mode_block),
    .count_zero(count_zero), .addr_hi_change(addr_hi_change), .HLDA(HLDA),
    .READY(READY), .EOP_N_in(EOP_N_in), .HRQ(HRQx), .AEN(AENx), .ADSTB(ADSTBx),
    .priority_gen(pgx), .ld_ack(ldx), .MEMR_N(MEMRx), .MEMW_N(MEMWx),
    .IOR_N(IORx), .IOW_N(IOWx), .upd_pulse(updx), .tc(tcx), .EOP_N_out(EOPx)
  );

  assign obs  = {HRQ, AEN, ADSTB, priority_gen, ld_ack, MEMR_N, MEMW_N, IOR_N, IOW_N,
                 upd_pulse, tc, EOP_N_out};
  assign obsX = {HRQx, AENx, ADSTBx, pgx, ldx, MEMRx, MEMWx, IORx, IOWx, updx, tcx, EOPx};

  // Bench-local phase tags for the expected trace.
  localparam int PI = 0, P0 = 1, P1 = 2, P2 = 3, P3 = 4, PW = 5, P4 = 6;

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic        dis;
    logic [1:0]  xfer;
    logic        blk;
    logic        cz;
    logic        ahc;
    logic        hlda;
    logic        rdy;
    logic        eopn;
    logic [11:0] exp;
    logic [11:0] expX;
  } cyc_t;

  cyc_t trace[$];
  cyc_t cur;

  function automatic logic [11:0] expOut(input int ph, input logic [1:0] xfer,
                                         input bit ext, input bit pg, input bit cz);
    bit busy, rd, wr, isRd, isWr, last;
    busy = (ph >= P1);
    rd   = (ph == P2) || (ph == P3) || (ph == PW);
    wr   = (ph == P3) || (ph == PW) || (ext && ph == P2);
    isRd = (xfer == 2'b10);
    isWr = (xfer == 2'b01);
    last = (ph == P4);
    return {ph != PI, busy, ph == P1, pg, busy, !(rd && isRd), !(wr && isWr),
            !(rd && isWr), !(wr && isRd), last, last && cz, !(last && cz)};
  endfunction

  task automatic emit(input int ph, input bit pg);
    cyc_t e;
    e      = cur;
    e.exp  = expOut(ph, cur.xfer, 1'b0, pg, cur.cz);
    e.expX = expOut(ph, cur.xfer, 1'b1, pg, cur.cz);
    trace.push_back(e);
  endtask

  task automatic emitRequest(input int hldaWait);
    cur.rst  = 1'b0;
    cur.hlda = 1'b0;
    emit(PI, 1'b0);
    repeat (hldaWait) emit(P0, 1'b0);
    cur.hlda = 1'b1;
    emit(P0, 1'b0);
  endtask

  task automatic emitTransfer(input bit viaS1, input bit pg, input int waits,
                              input bit cz, input bit eopAt, input bit ahc);
    cur.cz   = cz;
    cur.ahc  = ahc;
    cur.rdy  = 1'b1;
    cur.eopn = 1'b1;
    if (viaS1) emit(P1, pg);
    emit(P2, 1'b0);
    cur.rdy  = (waits == 0);
    cur.eopn = !eopAt;
    emit(P3, 1'b0);
    cur.eopn = 1'b1;
    for (int w = 1; w <= waits; w++) begin
      cur.rdy = (w == waits);
      emit(PW, 1'b0);
    end
    cur.rdy = 1'b1;
    emit(P4, 1'b0);
  endtask

  task automatic emitIdle(input int n);
    cur.req  = 4'd0;
    cur.hlda = 1'b0;
    cur.cz   = 1'b0;
    cur.ahc  = 1'b0;
    cur.dis  = 1'b0;
    repeat (n) emit(PI, 1'b0);
  endtask

  task automatic applyStimulus(input cyc_t c);
    RESET          = c.rst;
    dma_req        = c.req;
    ctrl_disable   = c.dis;
    mode_xfer      = c.xfer;
    mode_block     = c.blk;
    count_zero     = c.cz;
    addr_hi_change = c.ahc;
    HLDA           = c.hlda;
    READY          = c.rdy;
    EOP_N_in       = c.eopn;
    act_ch         = 2'($urandom_range(0, 3));
  endtask

  task automatic test_reset();
    logic [11:0] idle;
    idle = expOut(PI, 2'b00, 1'b0, 1'b0, 1'b0);
    cur  = '0;
    cur.rst = 1'b1; cur.req = 4'hF; cur.hlda = 1'b1; cur.xfer = 2'b10;
    cur.rdy = 1'b1; cur.eopn = 1'b0; cur.cz = 1'b1;
    applyStimulus(cur);
    repeat (3) @(negedge CLK);
    total++;
    if (obs !== idle) begin
      bad++;
      $display("[TB] FAIL reset_held: got %b want %b", obs, idle);
    end
    total++;
    if (obsX !== idle) begin
      bad++;
      $display("[TB] FAIL reset_held_ext: got %b want %b", obsX, idle);
    end
    cur = '0; cur.rdy = 1'b1; cur.eopn = 1'b1;
    applyStimulus(cur);
    @(negedge CLK);
    total++;
    if (obs !== idle) begin
      bad++;
      $display("[TB] FAIL reset_release: got %b want %b", obs, idle);
    end
  endtask

  task automatic test_single_read();
    trace.delete();
    cur.xfer = 2'b10; cur.blk = 1'b0; cur.req = 4'b0001;
    emitRequest(1);
    emitTransfer(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    emitIdle(2);
    foreach (trace[i]) begin
      total++;
      if (obs !== trace[i].exp) begin
        bad++;
        $display("[TB] FAIL single_read cyc %0d: got %b want %b", i, obs, trace[i].exp);
      end
      total++;
      if (obsX !== trace[i].expX) begin
        bad++;
        $display("[TB] FAIL single_read_ext cyc %0d: got %b want %b", i, obsX, trace[i].expX);
      end
      applyStimulus(trace[i]);
      @(negedge CLK);
    end
  endtask

  task automatic test_write_wait();
    trace.delete();
    cur.xfer = 2'b01; cur.blk = 1'b0; cur.req = 4'b0010;
    emitRequest(0);
    emitTransfer(1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    emitIdle(2);
    foreach (trace[i]) begin
      total++;
      if (obs !== trace[i].exp) begin
        bad++;
        $display("[TB] FAIL write_wait cyc %0d: got %b want %b", i, obs, trace[i].exp);
      end
      total++;
      if (obsX !== trace[i].expX) begin
        bad++;
        $display("[TB] FAIL write_wait_ext cyc %0d: got %b want %b", i, obsX, trace[i].expX);
      end
      applyStimulus(trace[i]);
      @(negedge CLK);
    end
  endtask

  task automatic test_block();
    trace.delete();
    cur.xfer = 2'b10; cur.blk = 1'b1; cur.req = 4'b0100;
    emitRequest(2);
    emitTransfer(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    emitTransfer(1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1);
    emitTransfer(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    emitIdle(2);
    foreach (trace[i]) begin
      total++;
      if (obs !== trace[i].exp) begin
        bad++;
        $display("[TB] FAIL block cyc %0d: got %b want %b", i, obs, trace[i].exp);
      end
      total++;
      if (obsX !== trace[i].expX) begin
        bad++;
        $display("[TB] FAIL block_ext cyc %0d: got %b want %b", i, obsX, trace[i].expX);
      end
      applyStimulus(trace[i]);
      @(negedge CLK);
    end
  endtask

  task automatic test_eop();
    trace.delete();
    cur.xfer = 2'b01; cur.blk = 1'b1; cur.req = 4'b0001;
    emitRequest(0);
    emitTransfer(1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    emitIdle(2);
    foreach (trace[i]) begin
      total++;
      if (obs !== trace[i].exp) begin
        bad++;
        $display("[TB] FAIL eop cyc %0d: got %b want %b", i, obs, trace[i].exp);
      end
      total++;
      if (obsX !== trace[i].expX) begin
        bad++;
        $display("[TB] FAIL eop_ext cyc %0d: got %b want %b", i, obsX, trace[i].expX);
      end
      applyStimulus(trace[i]);
      @(negedge CLK);
    end
  endtask

  task automatic test_abort();
    trace.delete();
    cur.xfer = 2'b01; cur.blk = 1'b0; cur.req = 4'b0010;
    emitRequest(0);
    cur.cz = 1'b0; cur.ahc = 1'b0; cur.rdy = 1'b1; cur.eopn = 1'b1;
    emit(P1, 1'b1);
    emit(P2, 1'b0);
    cur.rdy = 1'b0;
    emit(P3, 1'b0);
    emit(PW, 1'b0);
    cur.hlda = 1'b0;
    emit(PW, 1'b0);
    emitIdle(2);
    cur.xfer = 2'b10; cur.req = 4'b1000;
    emitRequest(1);
    cur.rdy = 1'b1;
    emit(P1, 1'b1);
    emit(P2, 1'b0);
    cur.rst = 1'b1;
    emit(P3, 1'b0);
    cur.rst = 1'b0;
    emitIdle(2);
    foreach (trace[i]) begin
      total++;
      if (obs !== trace[i].exp) begin
        bad++;
        $display("[TB] FAIL abort cyc %0d: got %b want %b", i, obs, trace[i].exp);
      end
      total++;
      if (obsX !== trace[i].expX) begin
        bad++;
        $display("[TB] FAIL abort_ext cyc %0d: got %b want %b", i, obsX, trace[i].expX);
      end
      applyStimulus(trace[i]);
      @(negedge CLK);
    end
  endtask

  task automatic test_verify_disable();
    trace.delete();
    cur.xfer = 2'b00; cur.blk = 1'b0; cur.req = 4'b0001;
    emitRequest(0);
    emitTransfer(1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    emitIdle(1);
    cur.xfer = 2'b11; cur.req = 4'b0100;
    emitRequest(1);
    emitTransfer(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    emitIdle(1);
    cur.dis = 1'b1; cur.req = 4'b1111;
    repeat (6) emit(PI, 1'b0);
    emitIdle(1);
    cur.req = 4'b0001;
    emit(PI, 1'b0);
    cur.req = 4'b0000;
    emit(P0, 1'b0);
    emitIdle(1);
    cur.xfer = 2'b10; cur.blk = 1'b1; cur.req = 4'b1000;
    emitRequest(0);
    cur.cz = 1'b0; cur.ahc = 1'b0; cur.rdy = 1'b1; cur.eopn = 1'b1;
    emit(P1, 1'b1);
    cur.dis = 1'b1;
    emit(P2, 1'b0);
    emit(P3, 1'b0);
    emit(P4, 1'b0);
    cur.req = 4'b1111;
    repeat (4) emit(PI, 1'b0);
    emitIdle(2);
    foreach (trace[i]) begin
      total++;
      if (obs !== trace[i].exp) begin
        bad++;
        $display("[TB] FAIL verify_disable cyc %0d: got %b want %b", i, obs, trace[i].exp);
      end
      total++;
      if (obsX !== trace[i].expX) begin
        bad++;
        $display("[TB] FAIL verify_disable_ext cyc %0d: got %b want %b", i, obsX, trace[i].expX);
      end
      applyStimulus(trace[i]);
      @(negedge CLK);
    end
  endtask

  // A service continues only in block mode while no tc, EOP or disable ends it.
  task automatic test_random();
    bit viaS1, pg, cz, eop, ahc;
    trace.delete();
    for (int s = 0; s < 25; s++) begin
      cur.xfer = 2'($urandom_range(0, 3));
      cur.blk  = 1'($urandom_range(0, 1));
      cur.req  = 4'($urandom_range(1, 15));
      emitRequest($urandom_range(0, 3));
      viaS1 = 1'b1;
      pg    = 1'b1;
      for (int t = 0; t < 5; t++) begin
        eop = ($urandom_range(0, 7) == 0);
        cz  = ($urandom_range(0, 3) == 0) || (t == 4);
        ahc = 1'($urandom_range(0, 1));
        emitTransfer(viaS1, pg, $urandom_range(0, 3), cz, eop, ahc);
        pg = 1'b0;
        if (!cur.blk || cz || eop) break;
        viaS1 = ahc;
      end
      emitIdle($urandom_range(1, 2));
    end
    foreach (trace[i]) begin
      total++;
      if (obs !== trace[i].exp) begin
        bad++;
        $display("[TB] FAIL random cyc %0d: got %b want %b", i, obs, trace[i].exp);
      end
      total++;
      if (obsX !== trace[i].expX) begin
        bad++;
        $display("[TB] FAIL random_ext cyc %0d: got %b want %b", i, obsX, trace[i].expX);
      end
      applyStimulus(trace[i]);
      @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_wait();
    test_block();
    test_eop();
    test_abort();
    test_verify_disable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
